// File: rtl/mem_responder_if.sv
// Request/acknowledge/answer bundle between a data cache (master) and the
// main-memory responder (slave).
interface mem_responder_if #(
   parameter int IDX_W = 16,
   parameter int TAG_W = 4
);
   logic [1:0]       qry_cmd;
   logic [IDX_W-1:0] qry_idx;
   logic [63:0]      qry_blk;
   logic [TAG_W-1:0] ack;
   logic [TAG_W-1:0] ans_tag;
   logic [63:0]      ans_blk;

   modport master (
      output qry_cmd, qry_idx, qry_blk,
      input  ack, ans_tag, ans_blk
   );

   modport slave (
      input  qry_cmd, qry_idx, qry_blk,
      output ack, ans_tag, ans_blk
   );
endinterface

// File: rtl/mem_responder.sv
// Main-memory model: tags every accepted request, answers loads in order a
// fixed latency after acceptance, and holds DEPTH 64-bit blocks.
module mem_responder #(
   parameter int DEPTH   = 64,
   parameter int IDX_W   = 16,
   parameter int TAG_W   = 4,
   parameter int LATENCY = 4,
   parameter int MAX_OUT = 3
) (
   input logic           clock,
   input logic           reset,
   mem_responder_if.slave bus
);
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_STORE = 2'b10;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   logic [63:0]       r_mem     [DEPTH];
   logic [TAG_W-1:0]  r_pipeTag [LATENCY];
   logic [63:0]       r_pipeBlk [LATENCY];
   logic [TAG_W-1:0]  r_nextTag;
   logic [CNT_W-1:0]  r_count;

   logic              w_isLoad;
   logic              w_isStore;
   logic [TAG_W-1:0]  w_ack;
   logic              w_accLoad;
   logic              w_accStore;
   logic              w_ansValid;
   logic [ADDR_W-1:0] w_idx;
   logic [63:0]       w_readBlk;

   // Index bits above the store depth are intentionally dropped.
   generate
      if (IDX_W > ADDR_W) begin : g_idxHigh
         logic w_unused;
         assign w_unused = &{1'b0, bus.qry_idx[IDX_W-1:ADDR_W]};
      end
   endgenerate

   assign w_idx      = bus.qry_idx[ADDR_W-1:0];
   assign w_readBlk  = r_mem[w_idx];
   assign w_ansValid = (r_pipeTag[LATENCY-1] != '0);

   // Acknowledge decision; the count seen here is the registered one, so a
   // retiring answer never frees a slot in the same cycle.
   always_comb begin
      w_isLoad   = (bus.qry_cmd == CMD_LOAD);
      w_isStore  = (bus.qry_cmd == CMD_STORE);
      w_ack      = '0;
      if (!reset && (w_isStore || (w_isLoad && (r_count < MAX_CNT)))) begin
         w_ack = r_nextTag;
      end
      w_accLoad  = w_isLoad  && (w_ack != '0);
      w_accStore = w_isStore && (w_ack != '0);
   end

   assign bus.ack     = w_ack;
   assign bus.ans_tag = r_pipeTag[LATENCY-1];
   assign bus.ans_blk = r_pipeBlk[LATENCY-1];

   // Tag generator skips 0, which is reserved for "nothing".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_nextTag <= TAG_W'(1);
      end else if (w_ack != '0) begin
         r_nextTag <= (r_nextTag == {TAG_W{1'b1}}) ? TAG_W'(1) : r_nextTag + TAG_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_accStore) begin
         r_mem[w_idx] <= bus.qry_blk;
      end
   end

   // Empty pipeline slots carry tag 0 and zero data so the outputs read 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < LATENCY; k++) begin
            r_pipeTag[k] <= '0;
            r_pipeBlk[k] <= '0;
         end
      end else begin
         r_pipeTag[0] <= w_accLoad ? r_nextTag : '0;
         r_pipeBlk[0] <= w_accLoad ? w_readBlk : '0;
         for (int k = 1; k < LATENCY; k++) begin
            r_pipeTag[k] <= r_pipeTag[k-1];
            r_pipeBlk[k] <= r_pipeBlk[k-1];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         case ({w_accLoad, w_ansValid})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard of expected load answers.
module tb_mem_responder;
   localparam int LATENCY = 4;
   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_STORE = 2'b10;

   typedef struct {
      logic [3:0]  tag;
      logic [63:0] blk;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          monitorOn = 1'b0;
   exp_t        scoreQ [$];
   logic [63:0] modelMem [64];

   mem_responder_if #(.IDX_W(16), .TAG_W(4)) bus ();

   mem_responder #(
      .DEPTH(64), .IDX_W(16), .TAG_W(4), .LATENCY(LATENCY), .MAX_OUT(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Answer monitor: every cycle either pops the due entry or sees silence.
   always @(negedge clock) begin
      if (monitorOn) begin
         if (bus.ans_tag !== 4'd0) begin
            if (scoreQ.size() == 0) begin
               checkOutput("ansUnexpected", 64'(bus.ans_tag), 64'd0);
            end else begin
               exp_t e;
               e = scoreQ.pop_front();
               checkOutput("ansTag", 64'(bus.ans_tag), 64'(e.tag));
               checkOutput("ansBlk", bus.ans_blk, e.blk);
               checkOutput("ansCycle", 64'(cyc), 64'(e.cyc));
            end
         end else begin
            checkOutput("ansBlkIdle", bus.ans_blk, 64'd0);
            if (scoreQ.size() != 0 && scoreQ[0].cyc <= cyc) begin
               exp_t e;
               e = scoreQ.pop_front();
               checkOutput("ansMissing", 64'(bus.ans_tag), 64'(e.tag));
            end
         end
      end
   end

   // Drives one request for one cycle and checks the acknowledge mid-cycle.
   task automatic applyStimulus(input logic [1:0] cmd, input logic [15:0] idx,
                                input logic [63:0] blk, input logic [3:0] expAck,
                                input string name);
      exp_t e;
      bus.qry_cmd = cmd;
      bus.qry_idx = idx;
      bus.qry_blk = blk;
      @(negedge clock);
      checkOutput(name, 64'(bus.ack), 64'(expAck));
      if (expAck != 4'd0 && cmd == CMD_LOAD) begin
         e.tag = expAck;
         e.blk = modelMem[idx % 64];
         e.cyc = cyc + LATENCY;
         scoreQ.push_back(e);
      end
      @(posedge clock);
      if (expAck != 4'd0 && cmd == CMD_STORE) modelMem[idx % 64] = blk;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(CMD_NONE, 16'd0, 64'd0, 4'd0, "ackIdle");
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus.qry_cmd = CMD_NONE;
      scoreQ.delete();
      for (int i = 0; i < 64; i++) modelMem[i] = 64'd0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      bus.qry_cmd = CMD_NONE;
      bus.qry_idx = '0;
      bus.qry_blk = '0;
      for (int i = 0; i < 64; i++) modelMem[i] = 64'd0;
      #2;
      checkOutput("rstAck", 64'(bus.ack), 64'd0);
      checkOutput("rstAnsTag", 64'(bus.ans_tag), 64'd0);
      checkOutput("rstAnsBlk", bus.ans_blk, 64'd0);

      // Idle after reset, then store followed by a load of the same block.
      doReset();
      monitorOn = 1'b1;
      idle(3);
      applyStimulus(CMD_STORE, 16'd2, 64'hdeadbeefcc00ffee, 4'd1, "ackStore");
      applyStimulus(CMD_LOAD, 16'd2, 64'd0, 4'd2, "ackLoad");
      applyStimulus(2'b11, 16'd2, 64'd0, 4'd0, "ackBadCmd");
      idle(6);
      checkOutput("drain1", 64'(scoreQ.size()), 64'd0);

      // Outstanding limit: the fourth load waits until the first answer retires.
      doReset();
      applyStimulus(CMD_LOAD, 16'd0, 64'd0, 4'd1, "ackLoadA");
      applyStimulus(CMD_LOAD, 16'd1, 64'd0, 4'd2, "ackLoadB");
      applyStimulus(CMD_LOAD, 16'd2, 64'd0, 4'd3, "ackLoadC");
      applyStimulus(CMD_LOAD, 16'd3, 64'd0, 4'd0, "ackFullA");
      applyStimulus(CMD_LOAD, 16'd3, 64'd0, 4'd0, "ackFullB");
      applyStimulus(CMD_LOAD, 16'd3, 64'd0, 4'd4, "ackLoadD");
      idle(8);
      checkOutput("drain3", 64'(scoreQ.size()), 64'd0);

      // Tag wrap over sixteen stores.
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(CMD_STORE, 16'(i), {32'hcafe0000, 32'(i)},
                       (i == 15) ? 4'd1 : 4'(i + 1), "ackStoreWrap");
      end
      idle(6);

      // Reset in the middle of an in-flight load.
      applyStimulus(CMD_STORE, 16'd9, 64'h0123456789abcdef, 4'd2, "ackStore9");
      applyStimulus(CMD_LOAD, 16'd9, 64'd0, 4'd3, "ackLoad9");
      idle(1);
      bus.qry_cmd = CMD_LOAD;
      bus.qry_idx = 16'd9;
      reset = 1'b1;
      scoreQ.delete();
      for (int i = 0; i < 64; i++) modelMem[i] = 64'd0;
      #1;
      checkOutput("midRstAck", 64'(bus.ack), 64'd0);
      checkOutput("midRstAnsTag", 64'(bus.ans_tag), 64'd0);
      checkOutput("midRstAnsBlk", bus.ans_blk, 64'd0);
      @(posedge clock);
      @(posedge clock);
      #1;
      bus.qry_cmd = CMD_NONE;
      reset = 1'b0;
      idle(10);
      applyStimulus(CMD_LOAD, 16'd9, 64'd0, 4'd1, "ackAfterRst");
      idle(6);

      // Index aliasing modulo the store depth.
      doReset();
      applyStimulus(CMD_STORE, 16'd5, 64'h5555aaaa12345678, 4'd1, "ackStore5");
      applyStimulus(CMD_STORE, 16'd6, 64'h6666bbbb87654321, 4'd2, "ackStore6");
      applyStimulus(CMD_LOAD, 16'd5, 64'd0, 4'd3, "ackLoad5");
      applyStimulus(CMD_LOAD, 16'd69, 64'd0, 4'd4, "ackLoad69");
      idle(7);
      checkOutput("drain6", 64'(scoreQ.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
